// File: rtl/crp_pkg.sv
// Shared types and constants for the challenge/response sequencer.
package crp_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    OUTPUT  = 3'd4,
    FINISH  = 3'd5
  } crp_state_t;

  // Galois feedback mask for x^64 + x^63 + x^61 + x^60 + 1 (right-shifting form).
  localparam logic [63:0] CRP_LFSR_TAPS = 64'hD800_0000_0000_0000;

  // Challenge width of the inputNetwork this sequencer feeds.
  localparam int CRP_CW_DEFAULT = 64;

endpackage

// File: rtl/crp_lfsr.sv
// Right-shifting Galois LFSR producing the challenge stream; one shift per step.
module crp_lfsr
  import crp_pkg::*;
#(
  parameter int          CW   = CRP_CW_DEFAULT,
  parameter logic [CW-1:0] SEED = 64'hD0E7_20E9_A118_478C
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  output logic [CW-1:0] q
);

  // An all-zero state would lock the LFSR, so a zero seed is promoted to 1.
  localparam logic [CW-1:0] SEED_EFF = (SEED == '0) ? CW'(1) : SEED;
  localparam logic [CW-1:0] TAPS     = CRP_LFSR_TAPS[CW-1:0];

  // Advance on step; the reset value restarts the sequence at the seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED_EFF;
    end else if (step) begin
      q <= q[0] ? ((q >> 1) ^ TAPS) : (q >> 1);
    end
  end

endmodule

// File: rtl/crp_sequencer.sv
// Challenge source and response collector: launches the PUF, waits the settle
// time, samples the response and offers each CRP over valid/ready.
module crp_sequencer
  import crp_pkg::*;
#(
  parameter int            CW         = CRP_CW_DEFAULT,
  parameter int            SETTLE_CYC = 16,
  parameter logic [CW-1:0] SEED       = 64'hD0E7_20E9_A118_478C
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [15:0]   num_crp,
  output logic [CW-1:0] chal,
  output logic          launch,
  input  logic          resp_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_chal,
  output logic          out_resp,
  output logic          busy,
  output logic          done
);

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC);

  crp_state_t  state;
  crp_state_t  state_nxt;
  logic [7:0]  cnt;
  logic [15:0] remain;
  logic        handshake;

  // The LFSR output is the registered challenge; it only moves on an accepted CRP.
  crp_lfsr #(
    .CW   (CW),
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (handshake),
    .q     (chal)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    state_nxt = state;
    handshake = 1'b0;
    launch    = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = (num_crp == 16'd0) ? FINISH : LAUNCH;
      end
      LAUNCH: begin
        launch    = 1'b1;
        state_nxt = SETTLE;
      end
      SETTLE: begin
        if (cnt == 8'd1) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        state_nxt = OUTPUT;
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          handshake = 1'b1;
          state_nxt = (remain == 16'd1) ? FINISH : LAUNCH;
        end
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Settle countdown (loaded during LAUNCH) and remaining-CRP count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 8'd0;
      remain <= 16'd0;
    end else begin
      if (state == LAUNCH)      cnt <= SETTLE_LD;
      else if (state == SETTLE) cnt <= cnt - 8'd1;
      if (state == IDLE && start) remain <= num_crp;
      else if (handshake)         remain <= remain - 16'd1;
    end
  end

  // CRP output registers; held stable through any back-pressure in OUTPUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_chal <= '0;
      out_resp <= 1'b0;
    end else if (state == CAPTURE) begin
      out_chal <= chal;
      out_resp <= resp_in;
    end
  end

endmodule

// File: tb/tb_crp_sequencer.sv
// Directed testbench for crp_sequencer with SETTLE_CYC = 4.
module tb_crp_sequencer;

  localparam int          CW    = 64;
  localparam int          S     = 4;
  localparam logic [63:0] SEED  = 64'hD0E7_20E9_A118_478C;
  localparam logic [63:0] CHAL1 = 64'h6873_9074_D08C_23C6;
  localparam logic [63:0] CHAL2 = 64'h3439_C83A_6846_11E3;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [15:0]   num_crp;
  logic [CW-1:0] chal;
  logic          launch;
  logic          resp_in;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_chal;
  logic          out_resp;
  logic          busy;
  logic          done;

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int hs       = 0;
  int launches = 0;

  crp_sequencer #(
    .CW         (CW),
    .SETTLE_CYC (S),
    .SEED       (SEED)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_crp   (num_crp),
    .chal      (chal),
    .launch    (launch),
    .resp_in   (resp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chal  (out_chal),
    .out_resp  (out_resp),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count handshakes and launch pulses as the DUT sees them on each edge.
  always @(posedge clk) begin
    if (out_valid && out_ready) hs <= hs + 1;
    if (launch)                 launches <= launches + 1;
  end

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    lfsr_next = s[0] ? ((s >> 1) ^ 64'hD800_0000_0000_0000) : (s >> 1);
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [63:0] exp;
    logic        r;
    logic        stable;
    int          hs0;
    int          l0;

    rst_n = 1'b0; start = 1'b0; num_crp = 16'd0; resp_in = 1'b0; out_ready = 1'b0;

    // Reset state
    #2;
    step(2);
    chk("rst_chal", chal, SEED);
    chk("rst_launch", 64'(launch), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_resp", 64'(out_resp), 64'd0);
    chk("rst_out_chal", out_chal, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    step(10);
    chk("idle_busy", 64'(busy), 64'd0);

    // Single CRP
    num_crp = 16'd1; out_ready = 1'b1; resp_in = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("single_launch", 64'(launch), 64'd1);
    chk("single_busy", 64'(busy), 64'd1);
    step(3);
    chk("single_settle_chal", chal, SEED);
    chk("single_settle_valid", 64'(out_valid), 64'd0);
    step(3);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_out_chal", out_chal, SEED);
    chk("single_out_resp", 64'(out_resp), 64'd1);
    step();
    chk("single_done", 64'(done), 64'd1);
    chk("single_valid_drop", 64'(out_valid), 64'd0);
    chk("single_next_chal", chal, CHAL1);
    step();
    chk("single_idle_busy", 64'(busy), 64'd0);
    chk("single_done_pulse", 64'(done), 64'd0);

    // Back-pressure, 3 CRPs with 20 stalled cycles each
    out_ready = 1'b0; num_crp = 16'd3; exp = CHAL1; hs0 = hs;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      r = (k == 1);
      resp_in = r;
      chk("bp_launch", 64'(launch), 64'd1);
      chk("bp_chal", chal, exp);
      step(6);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_out_chal", out_chal, exp);
      chk("bp_out_resp", 64'(out_resp), 64'(r));
      resp_in = ~r;
      stable = 1'b1;
      repeat (20) begin
        step();
        if (!(out_valid === 1'b1 && out_chal === exp && out_resp === r &&
              launch === 1'b0 && chal === exp)) stable = 1'b0;
      end
      chk("bp_stall_stable", 64'(stable), 64'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      exp = lfsr_next(exp);
      chk("bp_chal_adv", chal, exp);
    end
    chk("bp_done", 64'(done), 64'd1);
    chk("bp_handshakes", 64'(hs - hs0), 64'd3);
    step();
    chk("bp_idle", 64'(busy), 64'd0);

    // Zero count
    num_crp = 16'd0; l0 = launches; start = 1'b1;
    step();
    start = 1'b0;
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_launch", 64'(launch), 64'd0);
    chk("zero_valid", 64'(out_valid), 64'd0);
    step();
    chk("zero_idle", 64'(busy), 64'd0);
    chk("zero_no_launch", 64'(launches - l0), 64'd0);
    chk("zero_chal_kept", chal, exp);

    // Reset during SETTLE of CRP 2 of 5
    out_ready = 1'b1; num_crp = 16'd5; resp_in = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(7);
    chk("mid_launch2", 64'(launch), 64'd1);
    step(2);
    chk("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_chal", chal, SEED);
    chk("mid_rst_out_chal", out_chal, 64'd0);
    #1;
    rst_n = 1'b1;
    step(2);
    num_crp = 16'd1; resp_in = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("rerun_launch", 64'(launch), 64'd1);
    step(6);
    chk("rerun_valid", 64'(out_valid), 64'd1);
    chk("rerun_out_chal", out_chal, SEED);
    chk("rerun_out_resp", 64'(out_resp), 64'd1);
    step();
    chk("rerun_done", 64'(done), 64'd1);
    chk("rerun_chal", chal, CHAL1);
    step();

    // start held high through a run of 2
    out_ready = 1'b1; num_crp = 16'd2; resp_in = 1'b0; l0 = launches; start = 1'b1;
    step();
    num_crp = 16'd9;
    step(6);
    chk("hold_out_chal1", out_chal, CHAL1);
    step();
    chk("hold_launch2", 64'(launch), 64'd1);
    step(6);
    chk("hold_out_chal2", out_chal, CHAL2);
    step();
    chk("hold_done", 64'(done), 64'd1);
    num_crp = 16'd1;
    step();
    chk("hold_idle", 64'(busy), 64'd0);
    chk("hold_launch_count", 64'(launches - l0), 64'd2);
    step();
    start = 1'b0;
    chk("hold_rerun_launch", 64'(launch), 64'd1);
    chk("hold_rerun_chal", chal, lfsr_next(CHAL2));
    step(6);
    chk("hold_rerun_out_chal", out_chal, lfsr_next(CHAL2));
    step();
    chk("hold_rerun_done", 64'(done), 64'd1);
    step();
    chk("hold_rerun_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/crp_sequencer.md
# crp_sequencer

Sequential challenge source and response collector for the XOR/LS-PUF datapath. It generates a pseudo-random challenge stream from an LFSR and drives each challenge into the `inputNetwork` `x` port. It pulses the arbiter-chain launch, waits a programmable settle time, and samples the 1-bit PUF response. Each challenge/response pair (CRP) is then offered to the host-side logger over a valid/ready handshake.

## Interface
- `CW`, 64: challenge width; must equal the `inputNetwork` width.
- `SETTLE_CYC`, 16: cycles between launch and response sample, legal range 1..255.
- `SEED`, 64'hD0E7_20E9_A118_478C: LFSR reset value; a value of 0 is replaced by 1.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level, sampled only in IDLE; begins a run.
- `num_crp`  in  16  number of CRPs in the run; latched on start.
- `chal`  out  CW  challenge to `inputNetwork.x`; registered.
- `launch`  out  1  one-cycle pulse that fires the PUF delay chains.
- `resp_in`  in  1  PUF response; assumed stable after settle.
- `out_valid`  out  1  CRP available.
- `out_ready`  in  1  consumer accepts the CRP.
- `out_chal`  out  CW  challenge belonging to the CRP.
- `out_resp`  out  1  sampled response.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at the end of a run.

## Operation
- States: IDLE, LAUNCH, SETTLE, CAPTURE, OUTPUT, FINISH.
- IDLE: on `start`=1, latch `num_crp` into `remain`.
  - If `num_crp`=0, go to FINISH.
  - Otherwise go to LAUNCH.
- LAUNCH: `launch`=1 for exactly this cycle. `chal` already holds the current LFSR value. Go to SETTLE.
- SETTLE: count down from SETTLE_CYC. After SETTLE_CYC cycles, go to CAPTURE.
- CAPTURE: register `out_resp`←`resp_in` and `out_chal`←`chal`. Go to OUTPUT.
- OUTPUT: hold `out_valid`=1 with stable data until `out_ready`=1. On that handshake edge:
  - advance the LFSR one step;
  - load `chal` with the new LFSR value;
  - decrement `remain`.
  - If `remain` was 1, go to FINISH; otherwise go to LAUNCH.
- FINISH: `done`=1 for one cycle, then go to IDLE.
- LFSR: 64-bit Galois, polynomial x^64+x^63+x^61+x^60+1, one shift per accepted CRP. It does not rewind between runs; a new run continues the sequence.
- `start` is ignored while `busy`. `num_crp` changes during a run have no effect.
- `chal` changes only on a handshake edge or at reset, never while SETTLE is counting.

## Timing
- Reset values:
  - state = IDLE;
  - `chal` = SEED (or 1 if SEED=0);
  - `launch`, `out_valid`, `out_resp`, `busy`, `done` = 0;
  - `out_chal` = 0;
  - counters = 0.
- Latency: `start` is sampled at edge E0. `launch` is high in cycle E0+1. `out_valid` rises at E0+SETTLE_CYC+3.
- Per-CRP period with `out_ready` tied high: SETTLE_CYC+3 cycles.
- `done` rises one cycle after the final handshake. `busy` falls on the following edge.
- Reset mid-run: asynchronous return to the reset values. No partial CRP is emitted. The LFSR reloads SEED.
- `out_ready` high outside OUTPUT has no effect.

## Structure
- Package `crp_pkg` holds:
  - the state enum `crp_state_t`;
  - the LFSR tap constant `CRP_LFSR_TAPS` = 64'hD800_0000_0000_0000;
  - the default CW.
- Sub-module `crp_lfsr`: parameters CW and SEED; ports `clk`, `rst_n`, `step`, `q`; async active-low reset to SEED.
- FSM, settle counter and output registers sit in `crp_sequencer`. `inputNetwork` is instantiated outside, by the integrating top.

## Test plan
- Reset: hold `rst_n`=0 → all outputs 0 except `chal`=64'hD0E7_20E9_A118_478C. After release and 10 idle cycles, `busy`=0.
- Single CRP: SETTLE_CYC=4, `num_crp`=1, `out_ready`=1, `resp_in`=1 → `launch` at E0+1 and `out_valid` at E0+7. The CRP carries `out_chal`=SEED and `out_resp`=1. `done` fires at E0+8, then `chal` equals the LFSR next state.
- Back-pressure: `num_crp`=3, `out_ready` low for 20 cycles per CRP → `out_valid` and data stay stable while stalled. Exactly 3 handshakes occur, the challenges match the reference LFSR model, and there is no relaunch before acceptance.
- Zero count: `num_crp`=0 → no `launch`, no `out_valid`, and a `done` pulse at E0+1.
- Reset during SETTLE of CRP 2 of 5 → immediate IDLE with `out_valid`=0 and `chal`=SEED. A fresh run with `num_crp`=1 then reproduces the single-CRP result.
- `start` held high through a run of 2 → exactly one run executes. A second run starts only after `done`, and its first challenge continues the LFSR sequence.
